// File: rtl/dma_chain_pkg.sv
// Shared definitions for the DMA descriptor sequencer: register map, START codes,
// FSM encoding and the packed queue entry layout.
package dma_chain_pkg;

  localparam logic [13:0] ADR_DESC_IO   = 14'h3FE8;
  localparam logic [13:0] ADR_DESC_MEM  = 14'h3FE9;
  localparam logic [13:0] ADR_DESC_CNT  = 14'h3FEA;
  localparam logic [13:0] ADR_CTRL      = 14'h3FEB;
  localparam logic [13:0] ADR_DMA_START = 14'h3FF0;
  localparam logic [13:0] ADR_DMA_IO    = 14'h3FF1;
  localparam logic [13:0] ADR_DMA_MEM   = 14'h3FF2;
  localparam logic [13:0] ADR_DMA_CNT   = 14'h3FF3;

  localparam logic [15:0] START_IO2MEM = 16'h0001;
  localparam logic [15:0] START_MEM2IO = 16'h0002;

  localparam int IO_W   = 12;
  localparam int MEM_W  = 12;
  localparam int CNT_W  = 13;
  localparam int DESC_W = IO_W + MEM_W + CNT_W + 2;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PROG_IO, ST_PROG_MEM, ST_PROG_CNT,
    ST_START, ST_ARM, ST_WAIT_DONE, ST_POP
  } seq_state_t;

  typedef struct packed {
    logic             irq_en;
    logic             dir;
    logic [CNT_W-1:0] cnt;
    logic [MEM_W-1:0] mem;
    logic [IO_W-1:0]  io;
  } desc_t;

  function automatic logic [15:0] start_code(input logic dir);
    return dir ? START_MEM2IO : START_IO2MEM;
  endfunction

endpackage

// File: rtl/dma_chain_ctrl_desc_fifo.sv
// Synchronous descriptor FIFO; clear can retain the head entry that is currently in flight.
module dma_desc_fifo
  import dma_chain_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  logic        keep_head,
  input  desc_t       wr_desc,
  output desc_t       head,
  output logic [AW:0] level,
  output logic        full,
  output logic        empty
);

  desc_t         mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]   level_reg;
  logic          push_ok, pop_ok, keep_ok;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == (AW+1)'(DEPTH));
  assign level   = level_reg;
  assign head    = mem_q[rd_ptr_reg];
  assign push_ok = push && !full && !clear;
  assign pop_ok  = pop && !empty;
  assign keep_ok = keep_head && !empty && !pop_ok;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_reg] <= wr_desc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (clear) begin
      // Flush everything behind the read pointer; a kept head survives as the only entry.
      rd_ptr_reg <= rd_ptr_reg + AW'(pop_ok);
      wr_ptr_reg <= rd_ptr_reg + AW'(pop_ok | keep_ok);
      level_reg  <= (AW+1)'(keep_ok);
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg <= level_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/dma_chain_ctrl.sv
// Descriptor sequencer: queues CPU-built descriptors, programs and kicks the DMA for each,
// and merges its register writes with CPU io writes (CPU always wins).
module dma_chain_ctrl
  import dma_chain_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rst_pipe,
  input  logic        cpu_io_we,
  input  logic [13:0] cpu_io_wadr,
  input  logic [15:0] cpu_io_wdata,
  input  logic [13:0] cpu_io_radr,
  input  logic [15:0] io_rdata_in,
  output logic [15:0] io_rdata,
  output logic        dma_io_we,
  output logic [13:0] dma_io_wadr,
  output logic [15:0] dma_io_wdata,
  input  logic [1:0]  dma_run,
  output logic        seq_busy,
  output logic        seq_irq
);

  seq_state_t        state_reg;
  logic [IO_W-1:0]   io_stage_reg;
  logic [MEM_W-1:0]  mem_stage_reg;
  logic [CNT_W-1:0]  cnt_stage_reg;
  logic              dir_stage_reg, irq_en_stage_reg;
  logic [7:0]        done_cnt_reg;
  logic              irq_reg, ovf_reg;
  logic              rd_sel_reg;
  logic [1:0]        rd_idx_reg;

  desc_t       head, stage_desc;
  logic [AW:0] level;
  logic        full, empty;
  logic        ctrl_wr, push_req, clear_req, ack_req, push_ok;
  logic [15:0] own_rdata;

  assign ctrl_wr    = cpu_io_we && (cpu_io_wadr == ADR_CTRL);
  assign push_req   = ctrl_wr && cpu_io_wdata[0];
  assign clear_req  = ctrl_wr && cpu_io_wdata[1];
  assign ack_req    = ctrl_wr && cpu_io_wdata[2];
  assign push_ok    = push_req && !clear_req && !full;
  assign stage_desc = {irq_en_stage_reg, dir_stage_reg, cnt_stage_reg, mem_stage_reg, io_stage_reg};

  dma_desc_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .pop       (!rst_pipe && (state_reg == ST_POP)),
    .clear     (rst_pipe || clear_req),
    .keep_head (!rst_pipe && (state_reg != ST_IDLE)),
    .wr_desc   (stage_desc),
    .head      (head),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || rst_pipe) begin
      io_stage_reg     <= '0;
      mem_stage_reg    <= '0;
      cnt_stage_reg    <= '0;
      dir_stage_reg    <= 1'b0;
      irq_en_stage_reg <= 1'b0;
    end else if (cpu_io_we) begin
      case (cpu_io_wadr)
        ADR_DESC_IO:  io_stage_reg  <= cpu_io_wdata[13:2];
        ADR_DESC_MEM: mem_stage_reg <= cpu_io_wdata[13:2];
        ADR_DESC_CNT: begin
          cnt_stage_reg    <= cpu_io_wdata[12:0];
          dir_stage_reg    <= cpu_io_wdata[14];
          irq_en_stage_reg <= cpu_io_wdata[15];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      done_cnt_reg <= '0;
      irq_reg      <= 1'b0;
      ovf_reg      <= 1'b0;
    end else if (rst_pipe) begin
      state_reg    <= ST_IDLE;
      done_cnt_reg <= '0;
      irq_reg      <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      if (push_req && !clear_req && full) ovf_reg <= 1'b1;
      if (state_reg == ST_POP && head.irq_en) irq_reg <= 1'b1;
      else if (ack_req)                       irq_reg <= 1'b0;
      if (state_reg == ST_POP) done_cnt_reg <= done_cnt_reg + 8'd1;
      // Programming states only advance on cycles where the CPU leaves the bus free.
      case (state_reg)
        ST_IDLE:      if ((!empty && !clear_req) || push_ok) state_reg <= ST_PROG_IO;
        ST_PROG_IO:   if (!cpu_io_we) state_reg <= ST_PROG_MEM;
        ST_PROG_MEM:  if (!cpu_io_we) state_reg <= ST_PROG_CNT;
        ST_PROG_CNT:  if (!cpu_io_we) state_reg <= ST_START;
        ST_START:     if (!cpu_io_we) state_reg <= ST_ARM;
        ST_ARM:       state_reg <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (dma_run == 2'b00) state_reg <= ST_POP;
        ST_POP:       state_reg <= (level > (AW+1)'(1) && !clear_req) ? ST_PROG_IO : ST_IDLE;
        default:      state_reg <= ST_IDLE;
      endcase
    end
  end

  assign seq_busy = (state_reg != ST_IDLE) || !empty;
  assign seq_irq  = irq_reg;

  always_comb begin
    dma_io_we    = 1'b0;
    dma_io_wadr  = '0;
    dma_io_wdata = '0;
    if (cpu_io_we) begin
      dma_io_we    = 1'b1;
      dma_io_wadr  = cpu_io_wadr;
      dma_io_wdata = cpu_io_wdata;
    end else begin
      case (state_reg)
        ST_PROG_IO: begin
          dma_io_we    = 1'b1;
          dma_io_wadr  = ADR_DMA_IO;
          dma_io_wdata = {2'b00, head.io, 2'b00};
        end
        ST_PROG_MEM: begin
          dma_io_we    = 1'b1;
          dma_io_wadr  = ADR_DMA_MEM;
          dma_io_wdata = {2'b00, head.mem, 2'b00};
        end
        ST_PROG_CNT: begin
          dma_io_we    = 1'b1;
          dma_io_wadr  = ADR_DMA_CNT;
          dma_io_wdata = {3'b000, head.cnt};
        end
        ST_START: begin
          dma_io_we    = 1'b1;
          dma_io_wadr  = ADR_DMA_START;
          dma_io_wdata = start_code(head.dir);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sel_reg <= 1'b0;
      rd_idx_reg <= '0;
    end else begin
      rd_sel_reg <= (cpu_io_radr[13:2] == ADR_DESC_IO[13:2]);
      rd_idx_reg <= cpu_io_radr[1:0];
    end
  end

  always_comb begin
    own_rdata = '0;
    case (rd_idx_reg)
      2'd0: own_rdata = {2'b00, io_stage_reg, 2'b00};
      2'd1: own_rdata = {2'b00, mem_stage_reg, 2'b00};
      2'd2: own_rdata = {irq_en_stage_reg, dir_stage_reg, 1'b0, cnt_stage_reg};
      2'd3: own_rdata = {1'b0, done_cnt_reg, ovf_reg, 1'b0, 3'(level), seq_busy, irq_reg};
      default: ;
    endcase
  end

  assign io_rdata = rd_sel_reg ? own_rdata : io_rdata_in;

endmodule

// File: tb/tb_dma_chain_ctrl.sv
// Directed bench for dma_chain_ctrl: drives CPU io writes and DMA run flags, checks the merged bus,
// status outputs and register readback against hand-computed values.
module tb_dma_chain_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, rst_pipe, cpu_io_we;
  logic [13:0] cpu_io_wadr, cpu_io_radr;
  logic [15:0] cpu_io_wdata, io_rdata_in, io_rdata;
  logic        dma_io_we;
  logic [13:0] dma_io_wadr;
  logic [15:0] dma_io_wdata;
  logic [1:0]  dma_run;
  logic        seq_busy, seq_irq;

  int n_vec = 0;
  int n_err = 0;

  dma_chain_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rst_pipe     (rst_pipe),
    .cpu_io_we    (cpu_io_we),
    .cpu_io_wadr  (cpu_io_wadr),
    .cpu_io_wdata (cpu_io_wdata),
    .cpu_io_radr  (cpu_io_radr),
    .io_rdata_in  (io_rdata_in),
    .io_rdata     (io_rdata),
    .dma_io_we    (dma_io_we),
    .dma_io_wadr  (dma_io_wadr),
    .dma_io_wdata (dma_io_wdata),
    .dma_run      (dma_run),
    .seq_busy     (seq_busy),
    .seq_irq      (seq_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    $display("vec %0d %s observed=%h expected=%h", n_vec, tag, obs, exp);
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic cpu_wr(input logic [13:0] a, input logic [15:0] d);
    cpu_io_we    = 1'b1;
    cpu_io_wadr  = a;
    cpu_io_wdata = d;
    cyc();
    cpu_io_we    = 1'b0;
  endtask

  task automatic chk_bus(input string tag, input logic we, input logic [13:0] a, input logic [15:0] d);
    #1;
    chk(tag, {1'b0, dma_io_we, dma_io_wadr, dma_io_wdata}, {1'b0, we, a, d});
  endtask

  task automatic rd(input logic [13:0] a, input string tag, input logic [15:0] exp);
    cpu_io_radr = a;
    cyc();
    #1;
    chk(tag, {16'h0, io_rdata}, {16'h0, exp});
    cpu_io_radr = '0;
  endtask

  task automatic stage(input logic [15:0] io, input logic [15:0] mem, input logic [15:0] cnt);
    cpu_wr(14'h3FE8, io);
    cpu_wr(14'h3FE9, mem);
    cpu_wr(14'h3FEA, cnt);
  endtask

  // Starts in the PROG_IO cycle with the CPU bus idle; ends in the cycle after POP.
  task automatic run_desc(input string tag, input logic [15:0] io, input logic [15:0] mem,
                          input logic [15:0] cnt, input logic [15:0] start);
    chk_bus({tag, ".3ff1"}, 1'b1, 14'h3FF1, io);    cyc();
    chk_bus({tag, ".3ff2"}, 1'b1, 14'h3FF2, mem);   cyc();
    chk_bus({tag, ".3ff3"}, 1'b1, 14'h3FF3, cnt);   cyc();
    chk_bus({tag, ".3ff0"}, 1'b1, 14'h3FF0, start); cyc();
    chk_bus({tag, ".arm"},  1'b0, 14'h0, 16'h0);
    dma_run = 2'b01;
    cyc();
    dma_run = 2'b00;
    cyc();
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; rst_pipe = 1'b0; cpu_io_we = 1'b0;
    cpu_io_wadr = '0; cpu_io_wdata = '0; cpu_io_radr = 14'h3FEB;
    io_rdata_in = 16'hBEEF; dma_run = 2'b00;
    repeat (2) @(posedge clk);
    #3;
    chk("rst.bus", {1'b0, dma_io_we, dma_io_wadr, dma_io_wdata}, 32'h0);
    chk("rst.busy", seq_busy, 0);
    chk("rst.irq", seq_irq, 0);
    chk("rst.rdata", io_rdata, 16'hBEEF);
    cpu_io_radr = '0;
    rst_n = 1'b1;
    cyc();

    // 1: single irq descriptor, 4-write program sequence on c1..c4
    stage(16'h0100, 16'h0040, 16'h8003);
    rd(14'h3FE8, "t1.rd_io", 16'h0100);
    rd(14'h3FE9, "t1.rd_mem", 16'h0040);
    rd(14'h3FEA, "t1.rd_cnt", 16'h8003);
    cpu_io_we = 1'b1; cpu_io_wadr = 14'h3FEB; cpu_io_wdata = 16'h0001;
    chk_bus("t1.cpu_fwd", 1'b1, 14'h3FEB, 16'h0001);
    cyc();
    cpu_io_we = 1'b0;
    chk("t1.busy", seq_busy, 1);
    chk("t1.irq_pre", seq_irq, 0);
    run_desc("t1", 16'h0100, 16'h0040, 16'h0003, 16'h0001);
    chk("t1.irq_post", seq_irq, 1);
    rd(14'h3FEB, "t1.ctrl", 16'h0081);
    cpu_wr(14'h3FEB, 16'h0004);
    #1 chk("t1.ack", seq_irq, 0);

    // 2: three chained descriptors, upper data bits ignored on the last one
    stage(16'h0200, 16'h0010, 16'h4001); cpu_wr(14'h3FEB, 16'h0001);
    stage(16'h0300, 16'h0020, 16'h0000); cpu_wr(14'h3FEB, 16'h0001);
    stage(16'hFFFF, 16'h3FFC, 16'hFFFF); cpu_wr(14'h3FEB, 16'h0001);
    run_desc("t2a", 16'h0200, 16'h0010, 16'h0001, 16'h0002);
    run_desc("t2b", 16'h0300, 16'h0020, 16'h0000, 16'h0001);
    run_desc("t2c", 16'h3FFC, 16'h3FFC, 16'h1FFF, 16'h0002);
    #1 chk("t2.busy", seq_busy, 0);
    rd(14'h3FEB, "t2.ctrl", 16'h0201);
    rd(14'h3FE8, "t2.rd_io", 16'h3FFC);
    rd(14'h3FEA, "t2.rd_cnt", 16'hDFFF);
    cpu_wr(14'h3FEB, 16'h0004);

    // 3: five pushes into a 4-deep queue while CPU writes stall the sequencer
    for (int i = 0; i < 5; i++) begin
      stage(16'h0400 + 16'(4 * i), 16'h0080, 16'(i));
      if (i == 4) cpu_io_radr = 14'h3FEB;
      cpu_wr(14'h3FEB, 16'h0001);
    end
    #1 chk("t3.ctrl", io_rdata, 16'h0252);
    cpu_io_radr = '0;
    for (int i = 0; i < 4; i++)
      run_desc("t3", 16'h0400 + 16'(4 * i), 16'h0080, 16'(i), 16'h0001);
    #1 chk("t3.busy", seq_busy, 0);

    // 4: CPU owns the bus for three cycles during PROG_IO
    stage(16'h0500, 16'h0100, 16'h0005);
    cpu_wr(14'h3FEB, 16'h0001);
    for (int k = 0; k < 3; k++) begin
      cpu_io_we = 1'b1; cpu_io_wadr = 14'h1000; cpu_io_wdata = 16'hAAAA + 16'(k);
      chk_bus("t4.cpu", 1'b1, 14'h1000, 16'hAAAA + 16'(k));
      cyc();
    end
    cpu_io_we = 1'b0;
    run_desc("t4", 16'h0500, 16'h0100, 16'h0005, 16'h0001);

    // 6: ack in the same cycle as POP of an irq descriptor keeps irq set
    stage(16'h0600, 16'h0200, 16'h8002);
    cpu_wr(14'h3FEB, 16'h0001);
    repeat (4) cyc();
    dma_run = 2'b10;
    cyc();
    dma_run = 2'b00;
    cyc();
    #1 chk("t6.irq_pre", seq_irq, 0);
    cpu_io_we = 1'b1; cpu_io_wadr = 14'h3FEB; cpu_io_wdata = 16'h0004;
    cyc();
    cpu_io_we = 1'b0;
    #1 chk("t6.irq_hold", seq_irq, 1);

    // 5: rst_pipe while waiting on the DMA with two more queued
    repeat (3) cpu_wr(14'h3FEB, 16'h0001);
    repeat (4) cyc();
    dma_run = 2'b01;
    cyc();
    cyc();
    #1 chk("t5.wait_busy", seq_busy, 1);
    rst_pipe = 1'b1;
    cyc();
    rst_pipe = 1'b0;
    dma_run = 2'b00;
    chk_bus("t5.bus", 1'b0, 14'h0, 16'h0);
    chk("t5.busy", seq_busy, 0);
    chk("t5.irq", seq_irq, 0);
    rd(14'h3FEB, "t5.ctrl", 16'h0000);
    rd(14'h3FE8, "t5.rd_io", 16'h0000);

    // push and clear in one write: clear wins
    cpu_wr(14'h3FEB, 16'h0003);
    #1 chk("t7.busy", seq_busy, 0);

    // clear during an active transfer keeps only the head
    repeat (3) cpu_wr(14'h3FEB, 16'h0001);
    cpu_io_radr = 14'h3FEB;
    cpu_wr(14'h3FEB, 16'h0002);
    #1 chk("t8.ctrl", io_rdata, 16'h0006);
    cpu_io_radr = '0;
    run_desc("t8", 16'h0000, 16'h0000, 16'h0000, 16'h0001);
    #1 chk("t8.busy", seq_busy, 0);
    chk("t8.passthru", io_rdata, 16'hBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
